// File: rtl/vrsm_dma_pkg.sv
// ============================================================================
// Module   : vrsm_dma_pkg
// Brief    : Shared sizes, types and FSM states for the ring-buffer burst arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package vrsm_dma_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int BURST_LENGTH = 128;
    localparam int NUM_LANE     = 4;
    localparam int DEPTH        = NUM_LANE * BURST_LENGTH;

    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int BEAT_W = $clog2(BURST_LENGTH + 1);
    localparam int LANE_W = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;

    typedef logic [OCC_W-1:0]  occ_t;
    typedef logic [BEAT_W-1:0] beat_cnt_t;
    typedef logic [LANE_W-1:0] lane_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first requester after the last winner.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import vrsm_dma_pkg::*;
(
    input  logic [NUM_LANE-1:0] i_req,
    input  lane_idx_t           i_last,
    output logic [NUM_LANE-1:0] o_gnt,
    output lane_idx_t           o_idx,
    output logic                o_any
);

    int w_pos;

    // Walk the lanes starting one past the last winner; first hit wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = 0;
        for (int k = 1; k <= NUM_LANE; k++) begin
            w_pos = (int'(i_last) + k) % NUM_LANE;
            if (!o_any && i_req[lane_idx_t'(w_pos)]) begin
                o_any = 1'b1;
                o_idx = lane_idx_t'(w_pos);
            end
        end
        if (o_any) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ring_buffer_burst_arbiter.sv
// ============================================================================
// Module   : ring_buffer_burst_arbiter
// Brief    : Grants whole bursts from DMA lanes onto the ring_buffer write port,
//            only when a full burst of free space can be reserved.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ring_buffer_burst_arbiter
    import vrsm_dma_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_LANE-1:0]            lane_req,
    output logic [NUM_LANE-1:0]            lane_gnt,
    input  logic [NUM_LANE-1:0]            lane_valid,
    input  logic [NUM_LANE*DATA_WIDTH-1:0] lane_data,
    output logic [NUM_LANE-1:0]            lane_ready,
    output logic                           rb_wen,
    output logic [DATA_WIDTH-1:0]          rb_din,
    input  logic                           rb_ren,
    input  logic                           rb_full,
    input  logic                           rb_empty,
    output logic [OCC_W-1:0]               occupancy,
    output logic                           busy,
    output logic                           ovf_err
);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    beat_cnt_t           r_beat_cnt;
    lane_idx_t           r_rr_ptr;
    lane_idx_t           r_owner;
    occ_t                r_occ;
    logic                r_ovf;

    logic [NUM_LANE-1:0] w_arb_gnt;
    lane_idx_t           w_arb_idx;
    logic                w_arb_any;
    logic [DATA_WIDTH-1:0] w_lane_word [NUM_LANE];
    occ_t                w_committed;
    logic                w_space_ok;
    logic                w_owner_valid;
    logic                w_beat;
    logic                w_last_beat;
    logic                w_occ_inc;
    logic                w_occ_dec;

    generate
        for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane_word
            assign w_lane_word[g] = lane_data[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_arbiter u_rr_arbiter (
        .i_req  (lane_req),
        .i_last (r_rr_ptr),
        .o_gnt  (w_arb_gnt),
        .o_idx  (w_arb_idx),
        .o_any  (w_arb_any)
    );

    // Words in flight for an unfinished burst count as already occupied.
    assign w_committed   = r_occ + occ_t'(r_beat_cnt);
    assign w_space_ok    = (occ_t'(DEPTH) - w_committed) >= occ_t'(BURST_LENGTH);
    assign w_owner_valid = lane_valid[r_owner];
    assign w_beat        = (r_state == XFER) && w_owner_valid && !rb_full;
    assign w_last_beat   = w_beat && (r_beat_cnt == beat_cnt_t'(1));
    assign w_occ_inc     = rb_wen && !rb_full;
    assign w_occ_dec     = rb_ren && !rb_empty;

    always_comb begin
        w_state_nxt = r_state;
        lane_gnt    = '0;
        lane_ready  = '0;
        rb_wen      = 1'b0;
        rb_din      = '0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (|lane_req && w_space_ok) begin
                    w_state_nxt = ARB;
                end
            end
            ARB: begin
                busy        = 1'b1;
                lane_gnt    = w_arb_gnt;
                w_state_nxt = w_arb_any ? XFER : IDLE;
            end
            XFER: begin
                busy = 1'b1;
                if (!rb_full) begin
                    lane_ready[r_owner] = 1'b1;
                end
                rb_wen = w_beat;
                if (w_beat) begin
                    rb_din = w_lane_word[r_owner];
                end
                if (w_last_beat) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_rr_ptr   <= lane_idx_t'(NUM_LANE - 1);
            r_owner    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB && w_arb_any) begin
                r_rr_ptr   <= w_arb_idx;
                r_owner    <= w_arb_idx;
                r_beat_cnt <= beat_cnt_t'(BURST_LENGTH);
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt - beat_cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_occ_inc && !w_occ_dec && r_occ != occ_t'(DEPTH)) begin
                r_occ <= r_occ + occ_t'(1);
            end else if (w_occ_dec && !w_occ_inc && r_occ != '0) begin
                r_occ <= r_occ - occ_t'(1);
            end
            // A beat offered against a full buffer means the reservation was broken.
            if (r_state == XFER && w_owner_valid && rb_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign occupancy = r_occ;
    assign ovf_err   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_ring_buffer_burst_arbiter.sv
// ============================================================================
// Module   : tb_ring_buffer_burst_arbiter
// Brief    : Self-checking bench with vector table, directed corners and a
//            random run against a burst-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ring_buffer_burst_arbiter;
    import vrsm_dma_pkg::*;

    logic                           clk;
    logic                           rst;
    logic [NUM_LANE-1:0]            lane_req;
    logic [NUM_LANE-1:0]            lane_gnt;
    logic [NUM_LANE-1:0]            lane_valid;
    logic [NUM_LANE*DATA_WIDTH-1:0] lane_data;
    logic [NUM_LANE-1:0]            lane_ready;
    logic                           rb_wen;
    logic [DATA_WIDTH-1:0]          rb_din;
    logic                           rb_ren;
    logic                           rb_full;
    logic                           rb_empty;
    logic [OCC_W-1:0]               occupancy;
    logic                           busy;
    logic                           ovf_err;

    logic force_full;
    int   rb_cnt;
    int   rb_delta;

    int n_pass  = 0;
    int n_total = 0;

    ring_buffer_burst_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .lane_req   (lane_req),
        .lane_gnt   (lane_gnt),
        .lane_valid (lane_valid),
        .lane_data  (lane_data),
        .lane_ready (lane_ready),
        .rb_wen     (rb_wen),
        .rb_din     (rb_din),
        .rb_ren     (rb_ren),
        .rb_full    (rb_full),
        .rb_empty   (rb_empty),
        .occupancy  (occupancy),
        .busy       (busy),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word count of the ring_buffer itself; the arbiter must track it exactly.
    assign rb_full  = force_full || (rb_cnt == DEPTH);
    assign rb_empty = (rb_cnt == 0);

    always @(posedge clk or posedge rst) begin
        if (rst) rb_cnt <= 0;
        else     rb_cnt <= rb_cnt + rb_delta;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: burst-level view (who owns the port, beats left, last winner).
    int  m_left  = 0;
    int  m_owner = 0;
    int  m_last  = NUM_LANE - 1;
    bit  m_ovf   = 1'b0;
    bit  m_arb   = 1'b0;
    int  gnt_log[$];
    int  wen_cnt = 0;

    logic [NUM_LANE-1:0]   e_gnt;
    logic [NUM_LANE-1:0]   e_ready;
    logic [DATA_WIDTH-1:0] e_din;
    logic                  e_busy;
    bit                    m_beat;
    bit                    m_was_arb;
    int                    m_win;
    int                    m_left0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_gnt",   64'(lane_gnt),   64'd0);
            chk("rst_ready", 64'(lane_ready), 64'd0);
            chk("rst_wen",   64'(rb_wen),     64'd0);
            chk("rst_din",   64'(rb_din),     64'd0);
            chk("rst_busy",  64'(busy),       64'd0);
            chk("rst_ovf",   64'(ovf_err),    64'd0);
            chk("rst_occ",   64'(occupancy),  64'd0);
            m_left   = 0;
            m_last   = NUM_LANE - 1;
            m_ovf    = 1'b0;
            m_arb    = 1'b0;
            rb_delta = 0;
        end else begin
            m_win = -1;
            if (m_arb) begin
                for (int k = 1; k <= NUM_LANE; k++) begin
                    if (m_win < 0 && lane_req[(m_last + k) % NUM_LANE]) m_win = (m_last + k) % NUM_LANE;
                end
            end
            e_gnt = '0;
            if (m_win >= 0) e_gnt[m_win] = 1'b1;
            e_ready = '0;
            if (m_left > 0 && !rb_full) e_ready[m_owner] = 1'b1;
            m_beat = (m_left > 0) && lane_valid[m_owner] && !rb_full;
            e_din  = m_beat ? lane_data[m_owner*DATA_WIDTH +: DATA_WIDTH] : '0;
            e_busy = m_arb || (m_left > 0);

            chk("gnt",   64'(lane_gnt),   64'(e_gnt));
            chk("ready", 64'(lane_ready), 64'(e_ready));
            chk("wen",   64'(rb_wen),     64'(m_beat));
            chk("din",   64'(rb_din),     64'(e_din));
            chk("busy",  64'(busy),       64'(e_busy));
            chk("ovf",   64'(ovf_err),    64'(m_ovf));
            chk("occ",   64'(occupancy),  64'(rb_cnt));

            for (int i = 0; i < NUM_LANE; i++) if (lane_gnt[i]) gnt_log.push_back(i);
            if (rb_wen) wen_cnt++;
            rb_delta = int'(rb_wen && !rb_full) - int'(rb_ren && !rb_empty);

            if (m_left > 0 && lane_valid[m_owner] && rb_full) m_ovf = 1'b1;
            m_left0 = m_left;
            if (m_beat) m_left--;
            m_was_arb = m_arb;
            if (m_arb && m_win >= 0) begin
                m_owner = m_win;
                m_last  = m_win;
                m_left  = BURST_LENGTH;
            end
            m_arb = !m_was_arb && (m_left0 == 0) && (|lane_req) && ((DEPTH - rb_cnt) >= BURST_LENGTH);
        end
    end

    typedef struct {
        logic [NUM_LANE-1:0] req;
        logic [NUM_LANE-1:0] valid;
        logic                ff;
        logic [NUM_LANE-1:0] gnt;
        logic [NUM_LANE-1:0] ready;
        logic                wen;
        logic                bsy;
        logic                ovf;
        int                  occ;
    } vec_t;

    vec_t tbl[8];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst        = 1'b1;
        lane_req   = '0;
        lane_valid = '0;
        rb_ren     = 1'b0;
        force_full = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input int budget, input string name);
        int n0 = gnt_log.size();
        int k  = 0;
        while (gnt_log.size() == n0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(name, 64'(gnt_log.size() > n0), 64'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (busy && k < budget);
        chk(name, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        lane_req   = '0;
        lane_valid = '0;
        lane_data  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        rb_ren     = 1'b0;
        force_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy),      64'd0);
        chk("reset_occ",  64'(occupancy), 64'd0);
        chk("reset_gnt",  64'(lane_gnt),  64'd0);
        cyc();
        rst = 1'b0;

        // Grant latency, ready/valid gaps and the sticky overflow flag.
        tbl[0] = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 0};
        tbl[1] = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 0};
        tbl[2] = '{4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 0};
        tbl[3] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 1};
        tbl[4] = '{4'b0000, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1};
        tbl[5] = '{4'b0000, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1};
        tbl[6] = '{4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b1, 1};
        tbl[7] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b1, 2};
        for (int i = 0; i < 8; i++) begin
            cyc();
            lane_req   = tbl[i].req;
            lane_valid = tbl[i].valid;
            force_full = tbl[i].ff;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i),   64'(lane_gnt),   64'(tbl[i].gnt));
            chk($sformatf("vec%0d_ready", i), 64'(lane_ready), 64'(tbl[i].ready));
            chk($sformatf("vec%0d_wen", i),   64'(rb_wen),     64'(tbl[i].wen));
            chk($sformatf("vec%0d_busy", i),  64'(busy),       64'(tbl[i].bsy));
            chk($sformatf("vec%0d_ovf", i),   64'(ovf_err),    64'(tbl[i].ovf));
            chk($sformatf("vec%0d_occ", i),   64'(occupancy),  64'(tbl[i].occ));
        end

        // Reset in the middle of a burst abandons it immediately.
        cyc();
        lane_valid = 4'b0001;
        rst        = 1'b1;
        @(negedge clk);
        chk("midrst_wen",  64'(rb_wen),    64'd0);
        chk("midrst_busy", 64'(busy),      64'd0);
        chk("midrst_ovf",  64'(ovf_err),   64'd0);
        chk("midrst_occ",  64'(occupancy), 64'd0);
        cyc();
        rst        = 1'b0;
        lane_valid = '0;

        // Single lane, valid held high.
        cyc();
        gnt_log.delete();
        wen_cnt    = 0;
        lane_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        lane_req   = 4'b0001;
        lane_valid = 4'b0001;
        wait_gnt(10, "t2_grant");
        cyc();
        lane_req = '0;
        wait_idle(400, "t2_done");
        chk("t2_beats", 64'(wen_cnt),        64'd128);
        chk("t2_occ",   64'(occupancy),      64'd128);
        chk("t2_ngnt",  64'(gnt_log.size()), 64'd1);
        chk("t2_lane",  64'(gnt_log.size() > 0 ? gnt_log[0] : -1), 64'd0);
        lane_valid = '0;

        // All lanes requesting: four bursts in lane order, then the buffer is full.
        do_reset();
        gnt_log.delete();
        wen_cnt    = 0;
        lane_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        lane_req   = 4'b1111;
        lane_valid = 4'b1111;
        repeat (700) @(negedge clk);
        #1;
        chk("t3_ngnt",  64'(gnt_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_order%0d", i), 64'(gnt_log.size() > i ? gnt_log[i] : -1), 64'(i));
        end
        chk("t3_occ",   64'(occupancy), 64'd512);
        chk("t3_beats", 64'(wen_cnt),   64'd512);
        chk("t3_busy",  64'(busy),      64'd0);

        // Space gate: 448 held -> no grant; drain to 384 -> grant one cycle later.
        cyc();
        lane_req   = '0;
        lane_valid = '0;
        rb_ren     = 1'b1;
        repeat (63) cyc();
        cyc();
        rb_ren = 1'b0;
        @(negedge clk);
        chk("t4_occ448", 64'(occupancy), 64'd448);
        cyc();
        lane_req = 4'b0001;
        repeat (20) cyc();
        chk("t4_no_grant", 64'(gnt_log.size()), 64'd4);
        rb_ren = 1'b1;
        repeat (63) cyc();
        cyc();
        rb_ren = 1'b0;
        @(negedge clk);
        chk("t4_occ384",   64'(occupancy), 64'd384);
        chk("t4_gnt_wait", 64'(lane_gnt),  64'd0);
        @(negedge clk);
        chk("t4_gnt",      64'(lane_gnt),  64'b0001);

        // Simultaneous read and write keep occupancy flat; then 1-on/1-off valid.
        cyc();
        lane_req   = '0;
        lane_valid = 4'b0001;
        rb_ren     = 1'b1;
        wen_cnt    = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t5_occ_flat", 64'(occupancy), 64'd384);
            cyc();
        end
        rb_ren = 1'b0;
        for (int k = 0; k < 400; k++) begin
            lane_valid = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            #1;
            if (!busy) break;
            cyc();
        end
        chk("t5_done",  64'(busy),      64'd0);
        chk("t5_beats", 64'(wen_cnt),   64'd128);
        chk("t5_occ",   64'(occupancy), 64'd492);
        lane_valid = '0;

        // Random traffic against the model.
        do_reset();
        gnt_log.delete();
        for (int i = 0; i < 3000; i++) begin
            cyc();
            lane_req = 4'($urandom_range(15));
            for (int l = 0; l < NUM_LANE; l++) lane_valid[l] = ($urandom_range(3) != 0);
            lane_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            rb_ren     = 1'($urandom_range(1));
            force_full = ($urandom_range(63) == 0);
        end
        cyc();
        lane_req   = '0;
        lane_valid = 4'b1111;
        rb_ren     = 1'b0;
        force_full = 1'b0;
        wait_idle(400, "rand_drain");
        chk("rand_grants", 64'(gnt_log.size() > 4), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
